// File: rtl/sound_wave_ram_arb.sv
// Ch3 wave RAM (16x8) shared by CPU and ch3 fetcher; fetch always wins, 1-cycle latency for both.
// A CPU access colliding with a fetch is held one deep (cpu_busy); strobes arriving while held are dropped.
module sound_wave_ram_arb #(
  parameter int         WINDOW  = 2,
  parameter logic [7:0] OPEN_RD = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_rd,
  input  logic       cpu_wr,
  input  logic [3:0] cpu_addr,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic       cpu_busy,
  input  logic       ch3_active,
  input  logic       ch3_req,
  input  logic [3:0] ch3_addr,
  output logic       ch3_ack,
  output logic [7:0] ch3_data
);

  localparam logic [2:0] WIN_LOAD = 3'(WINDOW);

  typedef enum logic {IDLE, PEND} state_t;

  state_t     state;
  logic [7:0] ram [16];
  logic [3:0] last_addr;
  logic [2:0] win_cnt;
  logic       pend_rd, pend_wr;
  logic [3:0] pend_addr;
  logic [7:0] pend_din;

  logic       exec_rd, exec_wr, granted;
  logic [3:0] exec_addr, eff_addr;
  logic [7:0] exec_din;
  logic       cpu_strobe;

  assign cpu_strobe = cpu_rd | cpu_wr;

  // The CPU only gets the port in cycles without a fetch; a held access goes before any new strobe.
  always_comb begin
    exec_rd   = 1'b0;
    exec_wr   = 1'b0;
    exec_addr = cpu_addr;
    exec_din  = cpu_din;
    if (!ch3_req) begin
      if (state == PEND) begin
        exec_wr   = pend_wr;
        exec_rd   = pend_rd & ~pend_wr;
        exec_addr = pend_addr;
        exec_din  = pend_din;
      end else begin
        exec_wr = cpu_wr;
        exec_rd = cpu_rd & ~cpu_wr;
      end
    end
    granted  = !ch3_active || (win_cnt != 3'd0);
    eff_addr = ch3_active ? last_addr : exec_addr;
  end

  // RAM has no reset so wave data survives rst.
  always_ff @(posedge clk) begin
    if (!rst && exec_wr && granted) begin
      ram[eff_addr] <= exec_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cpu_dout  <= 8'hFF;
      cpu_busy  <= 1'b0;
      ch3_ack   <= 1'b0;
      ch3_data  <= 8'h00;
      last_addr <= 4'd0;
      win_cnt   <= 3'd0;
      pend_rd   <= 1'b0;
      pend_wr   <= 1'b0;
      pend_addr <= 4'd0;
      pend_din  <= 8'h00;
    end else begin
      ch3_ack <= ch3_req;
      if (ch3_req) begin
        ch3_data  <= ram[ch3_addr];
        last_addr <= ch3_addr;
      end

      if (!ch3_active) begin
        win_cnt <= 3'd0;
      end else if (ch3_req) begin
        win_cnt <= WIN_LOAD;
      end else if (win_cnt != 3'd0) begin
        win_cnt <= win_cnt - 3'd1;
      end

      if (exec_rd) begin
        cpu_dout <= granted ? ram[eff_addr] : OPEN_RD;
      end

      case (state)
        IDLE: begin
          if (ch3_req && cpu_strobe) begin
            state     <= PEND;
            cpu_busy  <= 1'b1;
            pend_rd   <= cpu_rd;
            pend_wr   <= cpu_wr;
            pend_addr <= cpu_addr;
            pend_din  <= cpu_din;
          end
        end
        PEND: begin
          if (!ch3_req) begin
            state    <= IDLE;
            cpu_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sound_wave_ram_arb.sv
// Directed bench for sound_wave_ram_arb: transaction-level model checked every cycle plus literal pins.
module tb_sound_wave_ram_arb;

  localparam int         WINDOW  = 2;
  localparam logic [7:0] OPEN_RD = 8'hFF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [3:0] cpu_addr = 4'd0;
  logic [7:0] cpu_din = 8'd0;
  logic [7:0] cpu_dout;
  logic       cpu_busy;
  logic       ch3_active = 1'b0;
  logic       ch3_req = 1'b0;
  logic [3:0] ch3_addr = 4'd0;
  logic       ch3_ack;
  logic [7:0] ch3_data;

  sound_wave_ram_arb #(.WINDOW(WINDOW), .OPEN_RD(OPEN_RD)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_busy(cpu_busy),
    .ch3_active(ch3_active), .ch3_req(ch3_req), .ch3_addr(ch3_addr),
    .ch3_ack(ch3_ack), .ch3_data(ch3_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  // ---------------- model: RAM array, one-deep queue of held CPU accesses, window counter
  typedef struct {
    bit         rd;
    bit         wr;
    logic [3:0] a;
    logic [7:0] d;
  } acc_t;

  logic [7:0] m_ram [16];
  logic [7:0] m_dout, m_data;
  bit         m_busy, m_ack;
  logic [3:0] m_last;
  int         m_win;
  acc_t       q[$];
  acc_t       cur;
  bit         have;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_dout = 8'hFF; m_busy = 0; m_ack = 0; m_data = 8'h00;
      m_last = 4'd0;  m_win = 0;
      q.delete();
    end else begin
      have  = 0;
      m_ack = ch3_req;
      if (ch3_req) begin
        if ((cpu_rd || cpu_wr) && q.size() == 0)
          q.push_back('{rd: cpu_rd, wr: cpu_wr, a: cpu_addr, d: cpu_din});
        m_data = m_ram[ch3_addr];
      end else if (q.size() != 0) begin
        cur = q.pop_front(); have = 1;
      end else if (cpu_rd || cpu_wr) begin
        cur = '{rd: cpu_rd, wr: cpu_wr, a: cpu_addr, d: cpu_din}; have = 1;
      end
      if (have) begin
        if (!ch3_active) begin
          if (cur.wr) m_ram[cur.a] = cur.d;
          else        m_dout = m_ram[cur.a];
        end else if (m_win > 0) begin
          if (cur.wr) m_ram[m_last] = cur.d;
          else        m_dout = m_ram[m_last];
        end else if (!cur.wr) begin
          m_dout = OPEN_RD;
        end
      end
      if (ch3_req) m_last = ch3_addr;
      if (!ch3_active)  m_win = 0;
      else if (ch3_req) m_win = WINDOW;
      else if (m_win > 0) m_win = m_win - 1;
      m_busy = (q.size() != 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check8("cyc_cpu_dout", cpu_dout, m_dout);
      check8("cyc_cpu_busy", {7'd0, cpu_busy}, {7'd0, m_busy});
      check8("cyc_ch3_ack",  {7'd0, ch3_ack},  {7'd0, m_ack});
      check8("cyc_ch3_data", ch3_data, m_data);
    end
  end

  // ---------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_rd = 0; cpu_wr = 0; ch3_req = 0;
  endtask

  task automatic fetch(input logic [3:0] a, input logic [7:0] exp, input string name);
    idle(); ch3_req = 1; ch3_addr = a;
    tick();
    idle();
    check8(name, ch3_data, exp);
  endtask

  initial begin
    rst = 1;
    tick();
    chk_en = 1;
    tick();
    check8("rst_dout", cpu_dout, 8'hFF);
    check8("rst_busy", {7'd0, cpu_busy}, 8'd0);
    check8("rst_ack",  {7'd0, ch3_ack},  8'd0);
    check8("rst_data", ch3_data, 8'h00);
    rst = 0;

    // fill RAM with (0x11*i)^0x80, except RAM[7]=0x3C
    ch3_active = 0;
    for (int i = 0; i < 16; i++) begin
      cpu_wr = 1; cpu_addr = 4'(i);
      cpu_din = (i == 7) ? 8'h3C : (8'(i * 17) ^ 8'h80);
      tick();
    end
    idle();

    // 1: write then read same address, inactive
    cpu_wr = 1; cpu_addr = 4'd3; cpu_din = 8'hA5; tick();
    cpu_wr = 0; cpu_rd = 1; tick();
    idle();
    check8("t1_dout", cpu_dout, 8'hA5);
    check8("t1_busy", {7'd0, cpu_busy}, 8'd0);

    // 2: redirected read inside window, blocked read outside it
    ch3_active = 1;
    fetch(4'd7, 8'h3C, "t2_fetch7");
    cpu_rd = 1; cpu_addr = 4'd2; tick(); idle();
    check8("t2_redirect", cpu_dout, 8'h3C);
    tick(); tick();
    cpu_rd = 1; cpu_addr = 4'd2; tick(); idle();
    check8("t2_blocked", cpu_dout, 8'hFF);

    // 3: write WINDOW+1 cycles after fetch is dropped
    fetch(4'd5, 8'hD5, "t3_fetch5");
    tick(); tick();
    cpu_wr = 1; cpu_addr = 4'd0; cpu_din = 8'h11; tick(); idle();
    ch3_active = 0;
    fetch(4'd5, 8'hD5, "t3_ram5");
    fetch(4'd0, 8'h80, "t3_ram0");

    // 4: collision while inactive
    cpu_wr = 1; cpu_addr = 4'd9; cpu_din = 8'h77; ch3_req = 1; ch3_addr = 4'd9;
    tick(); idle();
    check8("t4_old9", ch3_data, 8'h19);
    check8("t4_busy", {7'd0, cpu_busy}, 8'd1);
    tick();
    check8("t4_busy_clr", {7'd0, cpu_busy}, 8'd0);
    fetch(4'd9, 8'h77, "t4_new9");

    // 5: back-to-back fetches hold the pending write; strobe while busy dropped
    ch3_active = 1;
    cpu_wr = 1; cpu_addr = 4'd4; cpu_din = 8'h44; ch3_req = 1; ch3_addr = 4'd6;
    tick(); idle();
    ch3_req = 1; ch3_addr = 4'd6; cpu_rd = 1; cpu_addr = 4'd1;
    tick(); idle();
    check8("t5_ack2", {7'd0, ch3_ack}, 8'd1);
    check8("t5_busy_held", {7'd0, cpu_busy}, 8'd1);
    check8("t5_drop_rd", cpu_dout, 8'hFF);
    tick();
    check8("t5_busy_clr", {7'd0, cpu_busy}, 8'd0);
    ch3_active = 0;
    fetch(4'd6, 8'h44, "t5_ram6");
    fetch(4'd4, 8'hC4, "t5_ram4");

    // ch3_active falls while a read is pending: executes with its own address
    ch3_active = 1;
    cpu_rd = 1; cpu_addr = 4'd3; ch3_req = 1; ch3_addr = 4'd8;
    tick(); idle();
    ch3_active = 0;
    tick();
    check8("fall_rd", cpu_dout, 8'hA5);

    // simultaneous rd+wr is a write only
    cpu_rd = 1; cpu_wr = 1; cpu_addr = 4'd10; cpu_din = 8'h5A; tick(); idle();
    check8("rdwr_dout", cpu_dout, 8'hA5);
    fetch(4'd10, 8'h5A, "rdwr_ram10");

    // 6: reset while pending
    cpu_wr = 1; cpu_addr = 4'd2; cpu_din = 8'hEE; ch3_req = 1; ch3_addr = 4'd1;
    tick(); idle();
    check8("t6_busy", {7'd0, cpu_busy}, 8'd1);
    rst = 1; tick();
    check8("t6_busy_rst", {7'd0, cpu_busy}, 8'd0);
    check8("t6_dout_rst", cpu_dout, 8'hFF);
    check8("t6_ack_rst", {7'd0, ch3_ack}, 8'd0);
    rst = 0;
    fetch(4'd2, 8'hA2, "t6_ram2");
    fetch(4'd9, 8'h77, "t6_ram9");
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
